// File: rtl/per_l2_responder_if.sv
// Peripheral request/response bus between a master and the L2 responder.
//
// Handshake: the master raises req_i with add_i/wen_i/wdata_i/be_i/id_i
// stable and keeps them stable until gnt_o is seen high. The request
// transfers on the rising edge where req_i and gnt_o are both 1. The response
// transfers on the rising edge where r_valid_o is 1. There is no response
// backpressure, so the master must accept it in that cycle. r_opc_o, r_id_o
// and r_rdata_o are meaningful only while r_valid_o is 1.
interface per_l2_responder_if #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 1
);
  logic                      req_i;
  logic [PER_ADDR_WIDTH-1:0] add_i;
  logic                      wen_i;
  logic [31:0]               wdata_i;
  logic [3:0]                be_i;
  logic [PER_ID_WIDTH-1:0]   id_i;
  logic                      gnt_o;
  logic                      r_valid_o;
  logic                      r_opc_o;
  logic [PER_ID_WIDTH-1:0]   r_id_o;
  logic [31:0]               r_rdata_o;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i, id_i,
    output gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i, id_i,
    input  gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o
  );
endinterface

// File: rtl/per_l2_responder.sv
// Single-port word memory behind a peripheral request/response bus.
// Grants can be delayed by a fixed number of cycles, and every grant returns
// exactly one response one cycle later. Out-of-range accesses are answered
// with an error opcode and a marker data word, and they leave memory untouched.
module per_l2_responder #(
  parameter int                        ADDR_WIDTH     = 12,
  parameter int                        PER_ID_WIDTH   = 1,
  parameter int                        PER_ADDR_WIDTH = 32,
  parameter logic [PER_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1C000000,
  parameter int                        GNT_STALL      = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  per_l2_responder_if.slave   bus,
  output logic [31:0]         wr_count_o,
  output logic [31:0]         err_count_o,
  output logic                dbg_state_o
);

  localparam int                        DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]                STALL    = 4'(GNT_STALL);
  // The range check uses one extra bit so that BASE_ADDR + span cannot wrap.
  localparam logic [PER_ADDR_WIDTH:0]   BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [PER_ADDR_WIDTH:0]   SPAN     = (PER_ADDR_WIDTH + 1)'(4) << ADDR_WIDTH;
  localparam logic [PER_ADDR_WIDTH:0]   LIMIT    = BASE_EXT + SPAN;
  localparam logic [31:0]               ERR_DATA = 32'hBADACCE5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t                  state_q;
  logic [3:0]              scnt_q, scnt_d;
  logic                    r_valid_q;
  logic                    r_opc_q, r_opc_d;
  logic [PER_ID_WIDTH-1:0] r_id_q;
  logic [31:0]             r_rdata_q, r_rdata_d;
  logic [31:0]             wr_count_q, wr_count_d;
  logic [31:0]             err_count_q, err_count_d;

  logic                    gnt;
  logic                    in_range;
  logic [PER_ADDR_WIDTH:0] add_ext;
  logic [ADDR_WIDTH-1:0]   widx;
  logic [31:0]             mem_q [DEPTH];

  // Grant once the request has been held for GNT_STALL cycles. A grant is
  // never given while reset is asserted.
  assign gnt       = bus.req_i & (scnt_q == STALL) & ~rst_i;
  assign bus.gnt_o = gnt;

  // Address decode: range check and word index. The index drops add_i[1:0].
  always_comb begin
    add_ext  = {1'b0, bus.add_i};
    in_range = (add_ext >= BASE_EXT) && (add_ext < LIMIT);
    widx     = bus.add_i[ADDR_WIDTH+1:2] - BASE_ADDR[ADDR_WIDTH+1:2];
  end

  // Next values of the stall counter, the response fields and the counters.
  always_comb begin
    scnt_d      = scnt_q;
    r_opc_d     = 1'b0;
    r_rdata_d   = 32'h0;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    if (!bus.req_i || gnt) begin
      scnt_d = 4'd0;
    end else if (scnt_q < STALL) begin
      scnt_d = scnt_q + 4'd1;
    end
    if (!in_range) begin
      r_opc_d   = 1'b1;
      r_rdata_d = ERR_DATA;
    end else if (bus.wen_i) begin
      r_rdata_d = mem_q[widx];
    end
    if (gnt) begin
      if (!in_range) begin
        err_count_d = err_count_q + 32'd1;
      end else if (!bus.wen_i) begin
        wr_count_d = wr_count_q + 32'd1;
      end
    end
  end

  // Storage: byte-masked writes on an in-range write grant. Reset does not clear it.
  always_ff @(posedge clk_i) begin
    if (gnt && in_range && !bus.wen_i) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be_i[b]) begin
          mem_q[widx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response FSM: every grant moves to RESP and loads the response registers
  // for the next cycle. RESP without a new grant returns to IDLE. In IDLE the
  // response fields keep their last values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      scnt_q      <= 4'd0;
      r_valid_q   <= 1'b0;
      r_opc_q     <= 1'b0;
      r_id_q      <= '0;
      r_rdata_q   <= 32'h0;
      wr_count_q  <= 32'h0;
      err_count_q <= 32'h0;
    end else begin
      scnt_q      <= scnt_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
      r_valid_q   <= gnt;
      if (gnt) begin
        r_opc_q   <= r_opc_d;
        r_id_q    <= bus.id_i;
        r_rdata_q <= r_rdata_d;
      end
      case (state_q)
        S_IDLE:  state_q <= gnt ? S_RESP : S_IDLE;
        S_RESP:  state_q <= gnt ? S_RESP : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.r_valid_o = r_valid_q;
  assign bus.r_opc_o   = r_opc_q;
  assign bus.r_id_o    = r_id_q;
  assign bus.r_rdata_o = r_rdata_q;
  assign wr_count_o    = wr_count_q;
  assign err_count_o   = err_count_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_per_l2_responder.sv
// Bench for per_l2_responder: one instance with no grant stall and one with a
// grant stall of 3 cycles. Responses of the no-stall instance are compared
// against a scoreboard queue that is filled from a local memory model.
module tb_per_l2_responder;

  localparam logic [32:0] BASE  = 33'h1C000000;
  localparam logic [32:0] LIMIT = 33'h1C004000;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] wr0, err0, wr3, err3;
  logic dbg0, dbg3;

  int checks = 0;
  int errors = 0;

  // Each entry is {opc, id, rdata}.
  logic [33:0] exp_q[$];
  logic [31:0] model_mem [4096];
  logic [31:0] exp_wr = 0;
  logic [31:0] exp_err = 0;

  per_l2_responder_if #(.PER_ADDR_WIDTH(32), .PER_ID_WIDTH(1)) bus0 ();
  per_l2_responder_if #(.PER_ADDR_WIDTH(32), .PER_ID_WIDTH(1)) bus3 ();

  per_l2_responder #(.GNT_STALL(0)) u0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0),
    .wr_count_o(wr0), .err_count_o(err0), .dbg_state_o(dbg0)
  );

  per_l2_responder #(.GNT_STALL(3)) u3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3),
    .wr_count_o(wr3), .err_count_o(err3), .dbg_state_o(dbg3)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: pop one expected response for every r_valid_o seen on u0.
  always @(negedge clk) begin
    logic [33:0] e;
    if (bus0.r_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got opc=%b id=%b rdata=%h, required no response",
                 bus0.r_opc_o, bus0.r_id_o, bus0.r_rdata_o);
      end else begin
        e = exp_q.pop_front();
        if ({bus0.r_opc_o, bus0.r_id_o, bus0.r_rdata_o} !== e) begin
          errors++;
          $display("FAIL resp_data: got opc=%b id=%b rdata=%h, required opc=%b id=%b rdata=%h",
                   bus0.r_opc_o, bus0.r_id_o, bus0.r_rdata_o, e[33], e[32], e[31:0]);
        end
      end
    end
  end

  // Drive one request on u0 and push its expected response from the model.
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic id);
    logic [32:0] a;
    logic        inr;
    logic [11:0] idx;
    logic [31:0] rd;
    @(posedge clk); #1;
    bus0.req_i   = 1'b1;
    bus0.wen_i   = wen;
    bus0.add_i   = addr;
    bus0.wdata_i = wdata;
    bus0.be_i    = be;
    bus0.id_i    = id;
    a   = {1'b0, addr};
    inr = (a >= BASE) && (a < LIMIT);
    idx = 12'((a - BASE) >> 2);
    if (!inr) begin
      rd = 32'hBADACCE5;
      exp_err++;
    end else if (wen) begin
      rd = model_mem[idx];
    end else begin
      rd = 32'h0;
      exp_wr++;
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    exp_q.push_back({~inr, id, rd});
    @(negedge clk);
    checks++;
    if (bus0.gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL gnt_same_cycle: got %b required 1 (addr %h)", bus0.gnt_o, addr);
    end
  endtask

  task automatic idle0();
    @(posedge clk); #1;
    bus0.req_i = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (wr0 !== exp_wr || err0 !== exp_err) begin
      errors++;
      $display("FAIL counts_%s: got wr=%0d err=%0d required wr=%0d err=%0d",
               tag, wr0, err0, exp_wr, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.req_i = 1'b1; bus0.wen_i = 1'b1; bus0.add_i = 32'h1C000000;
    bus0.wdata_i = 32'h0; bus0.be_i = 4'hF; bus0.id_i = 1'b1;
    bus3.req_i = 1'b1; bus3.wen_i = 1'b1; bus3.add_i = 32'h1C000000;
    bus3.wdata_i = 32'h0; bus3.be_i = 4'hF; bus3.id_i = 1'b1;
    #2;
    checks++;
    if ({bus0.gnt_o, bus0.r_valid_o, bus0.r_opc_o, bus0.r_id_o, bus0.r_rdata_o, wr0, err0, dbg0} !== '0) begin
      errors++;
      $display("FAIL reset_u0: got gnt=%b v=%b opc=%b id=%b rd=%h wr=%h err=%h st=%b required all 0",
               bus0.gnt_o, bus0.r_valid_o, bus0.r_opc_o, bus0.r_id_o, bus0.r_rdata_o, wr0, err0, dbg0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus3.gnt_o, bus3.r_valid_o, bus3.r_opc_o, bus3.r_id_o, bus3.r_rdata_o, wr3, err3, bus0.r_valid_o} !== '0) begin
      errors++;
      $display("FAIL reset_u3: got gnt=%b v=%b opc=%b id=%b rd=%h wr=%h err=%h v0=%b required all 0",
               bus3.gnt_o, bus3.r_valid_o, bus3.r_opc_o, bus3.r_id_o, bus3.r_rdata_o, wr3, err3, bus0.r_valid_o);
    end
    bus0.req_i = 1'b0;
    bus3.req_i = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_write_read();
    do_req(1'b0, 32'h1C000010, 32'hDEADBEEF, 4'hF, 1'b1);
    do_req(1'b1, 32'h1C000010, 32'h0, 4'hF, 1'b1);
    idle0();
    @(negedge clk);
    check_counts("write_read");
    checks++;
    if (wr0 !== 32'd1) begin
      errors++;
      $display("FAIL wr_count_first: got %0d required 1", wr0);
    end
  endtask

  task automatic test_byte_enables();
    do_req(1'b0, 32'h1C000000, 32'h11223344, 4'hF, 1'b0);
    do_req(1'b0, 32'h1C000000, 32'hAABBCCDD, 4'b0101, 1'b1);
    do_req(1'b1, 32'h1C000000, 32'h0, 4'hF, 1'b0);
    // A write with no byte enabled changes nothing but still counts.
    do_req(1'b0, 32'h1C000002, 32'hFFFFFFFF, 4'b0000, 1'b1);
    do_req(1'b1, 32'h1C000003, 32'h0, 4'hF, 1'b1);
    idle0();
    @(negedge clk);
    checks++;
    if (model_mem[0] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL be_model: got %h required 11bb33dd", model_mem[0]);
    end
    check_counts("byte_enables");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 32'h1C000000, 32'h0, 4'hF, 1'(i));
      if (i > 0) begin
        checks++;
        if (bus0.r_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_valid_%0d: got %b required 1", i - 1, bus0.r_valid_o);
        end
      end
    end
    idle0();
    @(negedge clk);
    checks++;
    if (bus0.r_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_valid_3: got %b required 1", bus0.r_valid_o);
    end
    @(negedge clk);
    checks++;
    if (bus0.r_valid_o !== 1'b0 || dbg0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got valid=%b state=%b required 0 0", bus0.r_valid_o, dbg0);
    end
  endtask

  task automatic test_out_of_range();
    do_req(1'b0, 32'h1C004000, 32'h55555555, 4'hF, 1'b1);
    do_req(1'b1, 32'h1BFFFFFC, 32'h0, 4'hF, 1'b0);
    do_req(1'b0, 32'h1C003FFC, 32'h0BADF00D, 4'hF, 1'b0);
    do_req(1'b1, 32'h1C003FFC, 32'h0, 4'hF, 1'b1);
    do_req(1'b1, 32'h1C000000, 32'h0, 4'hF, 1'b0);
    idle0();
    @(negedge clk);
    check_counts("out_of_range");
    checks++;
    if (err0 !== 32'd2) begin
      errors++;
      $display("FAIL err_count: got %0d required 2", err0);
    end
    // Response fields hold their last values while idle.
    @(negedge clk);
    checks++;
    if (bus0.r_valid_o !== 1'b0 || bus0.r_opc_o !== 1'b0 || bus0.r_id_o !== 1'b0 ||
        bus0.r_rdata_o !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL idle_hold: got v=%b opc=%b id=%b rd=%h required v=0 opc=0 id=0 rd=11bb33dd",
               bus0.r_valid_o, bus0.r_opc_o, bus0.r_id_o, bus0.r_rdata_o);
    end
  endtask

  task automatic test_random();
    for (int w = 32; w < 48; w++) begin
      do_req(1'b0, 32'h1C000000 + 32'(w * 4), $urandom, 4'hF, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 24; i++) begin
      do_req(1'($urandom_range(0, 1)), 32'h1C000000 + 32'($urandom_range(32, 47) * 4),
             $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    idle0();
    @(negedge clk);
    check_counts("random");
  endtask

  task automatic stall_cycle(input logic req, input logic exp_gnt, input int cyc);
    @(posedge clk); #1;
    bus3.req_i = req;
    @(negedge clk);
    checks++;
    if (bus3.gnt_o !== exp_gnt) begin
      errors++;
      $display("FAIL stall_gnt_c%0d: got %b required %b", cyc, bus3.gnt_o, exp_gnt);
    end
  endtask

  task automatic test_gnt_stall();
    bus3.wen_i = 1'b0; bus3.add_i = 32'h1C000008; bus3.wdata_i = 32'hCAFEF00D;
    bus3.be_i = 4'hF; bus3.id_i = 1'b1;
    stall_cycle(1'b1, 1'b0, 0);
    stall_cycle(1'b1, 1'b0, 1);
    stall_cycle(1'b1, 1'b0, 2);
    stall_cycle(1'b1, 1'b1, 3);
    stall_cycle(1'b0, 1'b0, 4);
    checks++;
    if ({bus3.r_valid_o, bus3.r_opc_o, bus3.r_id_o, bus3.r_rdata_o, wr3, dbg3} !==
        {1'b1, 1'b0, 1'b1, 32'h0, 32'd1, 1'b1}) begin
      errors++;
      $display("FAIL stall_write_resp: got v=%b opc=%b id=%b rd=%h wr=%0d st=%b required 1 0 1 0 1 1",
               bus3.r_valid_o, bus3.r_opc_o, bus3.r_id_o, bus3.r_rdata_o, wr3, dbg3);
    end
    // Request withdrawn in cycle 2, reasserted in cycle 3, granted in cycle 6.
    bus3.wen_i = 1'b1; bus3.id_i = 1'b0;
    stall_cycle(1'b1, 1'b0, 0);
    stall_cycle(1'b1, 1'b0, 1);
    stall_cycle(1'b0, 1'b0, 2);
    stall_cycle(1'b1, 1'b0, 3);
    stall_cycle(1'b1, 1'b0, 4);
    stall_cycle(1'b1, 1'b0, 5);
    stall_cycle(1'b1, 1'b1, 6);
    stall_cycle(1'b0, 1'b0, 7);
    checks++;
    if ({bus3.r_valid_o, bus3.r_opc_o, bus3.r_id_o, bus3.r_rdata_o} !== {1'b1, 1'b0, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL stall_read_resp: got v=%b opc=%b id=%b rd=%h required 1 0 0 cafef00d",
               bus3.r_valid_o, bus3.r_opc_o, bus3.r_id_o, bus3.r_rdata_o);
    end
  endtask

  task automatic test_reset_mid();
    do_req(1'b1, 32'h1C000010, 32'h0, 4'hF, 1'b1);
    @(posedge clk); #1;
    bus0.req_i = 1'b0;
    #1 rst = 1'b1;
    bus0.req_i = 1'b1;
    #1;
    void'(exp_q.pop_back());
    exp_wr  = 0;
    exp_err = 0;
    checks++;
    if (bus0.r_valid_o !== 1'b0 || bus0.gnt_o !== 1'b0 || wr0 !== 32'h0 || err0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b gnt=%b wr=%0d err=%0d required 0 0 0 0",
               bus0.r_valid_o, bus0.gnt_o, wr0, err0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus0.r_valid_o !== 1'b0 || bus0.gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got v=%b gnt=%b required 0 0", bus0.r_valid_o, bus0.gnt_o);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus0.gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL first_gnt_after_reset: got %b required 1", bus0.gnt_o);
    end
    exp_q.push_back({1'b0, 1'b1, 32'hDEADBEEF});
    idle0();
    @(negedge clk);
    check_counts("after_reset");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_gnt_stall();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL resp_missing: got %0d outstanding required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/per_l2_responder.md
PER_L2_RESPONDER -- requirements
Module: per_l2_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 12, log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter PER_ID_WIDTH, 1, width of request/response ID.
REQ-003 SHALL have parameter PER_ADDR_WIDTH, 32, peripheral address width.
REQ-004 SHALL have parameter BASE_ADDR, 32'h1C000000, byte address of word 0.
REQ-005 SHALL have parameter GNT_STALL, 0, cycles req_i must be held high before gnt_o asserts (0..15).
REQ-006 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port req_i  input  1  request valid.
REQ-009 SHALL have port add_i  input  PER_ADDR_WIDTH  byte address.
REQ-010 SHALL have port wen_i  input  1  0 = write, 1 = read.
REQ-011 SHALL have port wdata_i  input  32  write data.
REQ-012 SHALL have port be_i  input  4  byte enables, bit k selects wdata_i[8k+7:8k].
REQ-013 SHALL have port id_i  input  PER_ID_WIDTH  transaction ID.
REQ-014 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-015 SHALL have port r_valid_o  output  1  response valid.
REQ-016 SHALL have port r_opc_o  output  1  0 = OK, 1 = error (address out of range).
REQ-017 SHALL have port r_id_o  output  PER_ID_WIDTH  echoed ID of the granted request.
REQ-018 SHALL have port r_rdata_o  output  32  read data.
REQ-019 SHALL have port wr_count_o  output  32  count of granted in-range writes.
REQ-020 SHALL have port err_count_o  output  32  count of granted out-of-range requests.

Function
REQ-021 SHALL hold internal memory of 2**ADDR_WIDTH 32-bit words; memory SHALL NOT be cleared by reset.
REQ-022 SHALL keep stall counter scnt (4 bits): scnt <= 0 when req_i=0 or on grant; else scnt <= scnt+1 while scnt < GNT_STALL.
REQ-023 gnt_o SHALL be combinational: gnt_o = req_i AND (scnt == GNT_STALL); with GNT_STALL=0, gnt_o follows req_i in the same cycle.
REQ-024 A transaction is accepted ("granted") on a rising edge where req_i=1 and gnt_o=1; req_i dropping before grant SHALL leave no effect besides scnt reset.
REQ-025 In-range: BASE_ADDR <= add_i < BASE_ADDR + 4*2**ADDR_WIDTH, evaluated with PER_ADDR_WIDTH+1-bit arithmetic (no wrap); word index = (add_i - BASE_ADDR) >> 2; add_i[1:0] ignored.
REQ-026 Granted in-range write SHALL update only enabled bytes at the grant edge; be_i=4'b0000 SHALL be legal and change nothing but still count as a write.
REQ-027 Granted out-of-range request SHALL not touch memory.
REQ-028 FSM states IDLE (no response pending) and RESP (response driven); any grant -> RESP next cycle; RESP with no grant -> IDLE; RESP with grant -> RESP (back-to-back).
REQ-029 Response latency SHALL be exactly 1 cycle: r_valid_o=1 in the cycle after each grant, one response per grant, in order, no backpressure.
REQ-030 r_id_o SHALL equal id_i captured at grant; r_opc_o SHALL be 1 iff out of range.
REQ-031 r_rdata_o SHALL be: read in-range -> memory word as it was before the grant edge; write -> 32'h0; out-of-range -> 32'hBADACCE5.
REQ-032 In IDLE, r_opc_o, r_id_o, r_rdata_o SHALL hold their last values; only r_valid_o qualifies them.
REQ-033 wr_count_o and err_count_o SHALL increment by 1 per qualifying grant and wrap 32'hFFFFFFFF -> 0.

Reset
REQ-034 rst_i=1 SHALL immediately force FSM IDLE, scnt=0, r_valid_o=0, r_opc_o=0, r_id_o=0, r_rdata_o=0, wr_count_o=0, err_count_o=0.
REQ-035 A response pending when rst_i asserts SHALL be dropped; requests presented during reset SHALL NOT be granted and gnt_o SHALL be 0.
REQ-036 First grant SHALL be possible on the first rising edge after rst_i deasserts (GNT_STALL=0).

Verification
REQ-037 GNT_STALL=0: write 32'hDEADBEEF to 32'h1C000010 be=1111 id=1, then read same -> gnt same cycle as req; read response next cycle rdata=DEADBEEF, opc=0, id=1; wr_count_o=1.
REQ-038 Write 32'h11223344 be=1111, then 32'hAABBCCDD be=0101 to 32'h1C000000; read -> rdata=32'h11BB33DD.
REQ-039 Back-to-back: 4 reads on consecutive cycles, ids 0,1,0,1 -> r_valid_o high 4 consecutive cycles, ids 0,1,0,1 in order.
REQ-040 Out of range: write to 32'h1C004000 (ADDR_WIDTH=12) and read 32'h1BFFFFFC -> opc=1, rdata=BADACCE5, err_count_o=2, memory unchanged.
REQ-041 GNT_STALL=3: req held from cycle 0 -> gnt_o first high in cycle 3, response cycle 4; req dropped in cycle 2 and reasserted -> grant 3 cycles after reassertion.
REQ-042 Assert rst_i in the cycle after a grant -> r_valid_o falls immediately, no response emitted, counters 0, previously written data still readable afterwards.
